fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- drains bytes from an upstream FIFO and sends each one as a
// UART frame: start bit (0), 8 data bits LSB first, optional even parity bit,
// and a stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Configuration macro: UART_TX_PARITY_EN
//   undefined -> 10-bit frame, no parity logic is built
//   defined   -> 11-bit frame, even parity bit inserted between data and stop
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO registered read data (valid the cycle after a strobe)
//   fifo_rd_en  read strobe to the FIFO
//   tx          serial line, idles high, always driven from a flop
//   busy        high whenever the FSM is not in IDLE
//   frame_done  one-cycle pulse during the last cycle of the stop bit
//   dbg_state   current FSM state encoding, for observation only
//
// FIFO handshake: fifo_rd_en is a single-cycle pop strobe, raised only in IDLE
// while fifo_empty is low. The FIFO returns the byte on fifo_data in the next
// cycle (WAIT), where it is captured. fifo_empty and fifo_data are ignored in
// every other state, so at most one byte is taken per frame.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        rd_req;
  logic        done_d;
  logic        bit_end;

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as it arrives, since the shift register is
  // consumed while the data bits go out.
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      par_q <= ^fifo_data;
    end
  end
`endif

  assign bit_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_req  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          rd_req  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        baud_d  = 16'd0;
        shift_d = fifo_data;
        tx_d    = 1'b0;              // start bit appears on the next edge
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          bit_d   = bit_q + 3'd1;    // wraps 7->0 as the last bit finishes
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        baud_d  = 16'd0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // The strobe is gated by rst so it drops at once, even if fifo_empty is low.
  assign fifo_rd_en = rd_req & ~rst;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_d;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int N_A = 4;
  localparam int N_B = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic [7:0] data_a = 8'd0, data_b = 8'd0;
  logic       rd_a, tx_a, busy_a, fd_a;
  logic       rd_b, tx_b, busy_b, fd_b;
  logic [2:0] st_a, st_b;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] stim_q[$];

  int vectors = 0;
  int errors  = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(N_A)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_data(data_a),
    .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a),
    .dbg_state(st_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(N_B)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_data(data_b),
    .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b),
    .dbg_state(st_b)
  );

  // ---------------- FIFO models: registered read data, garbage otherwise ----
  always @(posedge clk) begin
    if (rd_a && q_a.size() > 0) data_a <= q_a.pop_front();
    else                        data_a <= 8'($urandom);
    empty_a <= (q_a.size() == 0);
  end

  always @(posedge clk) begin
    if (rd_b && q_b.size() > 0) data_b <= q_b.pop_front();
    else                        data_b <= 8'($urandom);
    empty_b <= (q_b.size() == 0);
  end

  // ---------------- reference: line level of a frame at bit index idx -------
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (FBITS == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Loads stim_q into the selected FIFO and checks every cycle of the
  // resulting frames plus a few idle cycles afterwards.
  task automatic run_frames(input int sel, input string name);
    int n, per, nb, total, k, off, t;
    logic [3:0] got, exp;
    logic [7:0] bytes[$];
    n     = (sel == 0) ? N_A : N_B;
    per   = 2 + FBITS * n;
    nb    = stim_q.size();
    total = nb * per + 4;
    bytes = stim_q;
    @(negedge clk);
    foreach (bytes[i]) begin
      if (sel == 0) q_a.push_back(bytes[i]);
      else          q_b.push_back(bytes[i]);
    end
    @(posedge clk);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      k   = c / per;
      off = c % per;
      if (k >= nb)       exp = 4'b0100;            // rd, tx, busy, fd
      else if (off == 0) exp = 4'b1100;
      else if (off == 1) exp = 4'b0110;
      else begin
        t   = off - 2;
        exp = {1'b0, frame_bit(bytes[k], t / n), 1'b1, (t == FBITS * n - 1)};
      end
      got = (sel == 0) ? {rd_a, tx_a, busy_a, fd_a} : {rd_b, tx_b, busy_b, fd_b};
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d byte %0d (0x%02h): rd/tx/busy/done=%b expected %b",
                 name, c, k, (k < nb) ? bytes[k] : 8'h00, got, exp);
      end
    end
    stim_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] b;
    int fd_cnt;
    b = 8'($urandom);
    @(negedge clk);
    q_a.push_back(b);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({rd_a, tx_a, busy_a, fd_a, rd_b, tx_b, busy_b, fd_b} !== 8'b0100_0100) begin
        errors++;
        $display("FAIL reset_hold: a=%b b=%b expected 0100 0100",
                 {rd_a, tx_a, busy_a, fd_a}, {rd_b, tx_b, busy_b, fd_b});
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (rd_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_strobe: rd=%b expected 1", rd_a);
    end
    @(negedge clk);
    vectors++;
    if ({rd_a, tx_a, busy_a} !== 3'b011) begin
      errors++;
      $display("FAIL reset_wait: rd/tx/busy=%b expected 011", {rd_a, tx_a, busy_a});
    end
    fd_cnt = 0;
    for (int t = 0; t < FBITS * N_A; t++) begin
      @(negedge clk);
      if (fd_a === 1'b1) fd_cnt++;
      vectors++;
      if (tx_a !== frame_bit(b, t / N_A)) begin
        errors++;
        $display("FAIL reset_frame t=%0d: tx=%b expected %b", t, tx_a, frame_bit(b, t / N_A));
      end
    end
    @(negedge clk);
    vectors++;
    if (fd_cnt != 1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_frame_end: done pulses=%0d busy=%b tx=%b expected 1 0 1",
               fd_cnt, busy_a, tx_a);
    end
  endtask

  task automatic test_idle_empty();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      vectors++;
      if ({rd_a, tx_a, busy_a, fd_a, rd_b, tx_b, busy_b, fd_b} !== 8'b0100_0100) begin
        errors++;
        $display("FAIL idle_empty cycle %0d: a=%b b=%b expected 0100 0100",
                 c, {rd_a, tx_a, busy_a, fd_a}, {rd_b, tx_b, busy_b, fd_b});
      end
    end
  endtask

  task automatic test_single();
    stim_q.push_back(8'hA5);
    run_frames(0, "single_a5");
    stim_q.push_back(8'h07);
    run_frames(0, "single_07");
  endtask

  task automatic test_back_to_back();
    stim_q.push_back(8'h01);
    stim_q.push_back(8'h80);
    run_frames(0, "back_to_back");
  endtask

  task automatic test_random();
    int nb;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) stim_q.push_back(8'($urandom));
      run_frames(0, "random_a");
    end
  endtask

  task automatic test_fast_clock();
    stim_q.push_back(8'hFF);
    run_frames(1, "fast_ff");
    for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom));
    run_frames(1, "fast_random");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'($urandom);
    @(negedge clk);
    q_a.push_back(b);
    @(posedge clk);
    repeat (19) @(posedge clk);   // middle of data bit 3
    #1;
    vectors++;
    if (tx_a !== b[3] || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_pre: tx/busy=%b%b expected %b1", tx_a, busy_a, b[3]);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({rd_a, tx_a, busy_a, fd_a} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_frame_abort: rd/tx/busy/done=%b expected 0100", {rd_a, tx_a, busy_a, fd_a});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      vectors++;
      if ({rd_a, tx_a, busy_a, fd_a} !== 4'b0100) begin
        errors++;
        $display("FAIL after_abort cycle %0d: rd/tx/busy/done=%b expected 0100",
                 c, {rd_a, tx_a, busy_a, fd_a});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single();
    test_back_to_back();
    test_random();
    test_fast_clock();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
